// File: rtl/intr_sequencer.sv
// -----------------------------------------------------------------------------
// intr_sequencer
//
// CPU-side interrupt entry sequencer. When the I/O ports block raises its
// latched interrupt flag and the control unit reports a legal interrupt point
// (or the CPU is halted), this block:
//   1. stalls fetch/decode and flushes the pipeline for DRAIN_CYCLES cycles,
//   2. pushes the return PC onto the stack (write at SP, pulse sp_dec),
//   3. reads the ISR start address from VECTOR_ADDR,
//   4. loads the PC with that vector and masks further interrupts until RTI.
// While the entry sequence runs, this block owns the data-memory port.
//
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   intr_flag         - pending interrupt level from the ports block
//   intr_clear        - one-cycle pulse clearing intr_flag (PUSH cycle)
//   halted            - HLT flag from the ports block
//   hlt_clear         - one-cycle pulse releasing halt (PUSH cycle, wake only)
//   instr_boundary    - control unit: this cycle is a legal interrupt point
//   rti               - control unit: RTI retiring this cycle
//   ret_pc            - PC to resume at after the ISR
//   sp                - current stack pointer
//   sp_dec            - decrement SP this cycle
//   stall, flush      - freeze fetch/decode, squash in-flight instructions
//   mem_we, mem_re    - data-memory write / read strobes
//   mem_addr          - data-memory address
//   mem_wdata         - data-memory write data
//   mem_rdata         - data-memory read data (one cycle after mem_re)
//   pc_load, pc_next  - PC load strobe and value
//   in_isr            - ISR active, nesting masked
//   busy              - sequencer not idle
// -----------------------------------------------------------------------------
module intr_sequencer #(
  parameter int                 DATA_W       = 8,
  parameter logic [DATA_W-1:0]  VECTOR_ADDR  = DATA_W'(8'h01),
  parameter int                 DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              intr_flag,
  output logic              intr_clear,
  input  logic              halted,
  output logic              hlt_clear,
  input  logic              instr_boundary,
  input  logic              rti,
  input  logic [DATA_W-1:0] ret_pc,
  input  logic [DATA_W-1:0] sp,
  output logic              sp_dec,
  output logic              stall,
  output logic              flush,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_next,
  output logic              in_isr,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_PUSH  = 3'd2,
    ST_VREQ  = 3'd3,
    ST_VLOAD = 3'd4
  } state_t;

  // Counter preload: the DRAIN state is left when the counter reads zero,
  // so loading N-1 gives exactly N drain cycles.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t              state_r;
  logic [3:0]          drain_cnt_r;
  logic [DATA_W-1:0]   saved_pc_r;
  logic                wake_pending_r;
  logic                in_isr_r;
  logic                accept_s;

  // Interrupt acceptance: only meaningful in IDLE, masked while an ISR runs.
  always_comb begin
    accept_s = intr_flag && !in_isr_r && (instr_boundary || halted);
  end

  // Entry-sequence state machine plus the ISR mask flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      drain_cnt_r    <= 4'd0;
      saved_pc_r     <= {DATA_W{1'b0}};
      wake_pending_r <= 1'b0;
      in_isr_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r        <= ST_DRAIN;
            saved_pc_r     <= ret_pc;
            drain_cnt_r    <= DRAIN_LOAD;
            wake_pending_r <= halted;
          end else begin
            state_r        <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_r == 4'd0) begin
            state_r     <= ST_PUSH;
          end else begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= drain_cnt_r - 4'd1;
          end
        end
        ST_PUSH:  state_r <= ST_VREQ;
        ST_VREQ:  state_r <= ST_VLOAD;
        ST_VLOAD: state_r <= ST_IDLE;
        default:  state_r <= ST_IDLE;
      endcase

      // Setting the mask on PC load wins; RTI only clears an active mask,
      // and is honoured regardless of sequencer state.
      if (state_r == ST_VLOAD) begin
        in_isr_r <= 1'b1;
      end else if (rti && in_isr_r) begin
        in_isr_r <= 1'b0;
      end else begin
        in_isr_r <= in_isr_r;
      end
    end
  end

  // Output decode from the registered state. pc_next passes memory read data
  // straight through in VLOAD because the vector arrives that very cycle.
  always_comb begin
    intr_clear = 1'b0;
    hlt_clear  = 1'b0;
    sp_dec     = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = {DATA_W{1'b0}};
    mem_wdata  = {DATA_W{1'b0}};
    pc_load    = 1'b0;
    pc_next    = {DATA_W{1'b0}};
    busy       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_DRAIN: begin
        stall = 1'b1;
        flush = 1'b1;
        busy  = 1'b1;
      end
      ST_PUSH: begin
        mem_we     = 1'b1;
        mem_addr   = sp;
        mem_wdata  = saved_pc_r;
        sp_dec     = 1'b1;
        intr_clear = 1'b1;
        hlt_clear  = wake_pending_r;
        stall      = 1'b1;
        busy       = 1'b1;
      end
      ST_VREQ: begin
        mem_re   = 1'b1;
        mem_addr = VECTOR_ADDR;
        stall    = 1'b1;
        busy     = 1'b1;
      end
      ST_VLOAD: begin
        pc_load = 1'b1;
        pc_next = mem_rdata;
        stall   = 1'b1;
        busy    = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign in_isr = in_isr_r;

endmodule

// File: tb/tb_intr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_intr_sequencer
//
// Directed bench for intr_sequencer with a small data-memory model. Inputs are
// driven on the falling edge; outputs are checked 1 time unit later.
// -----------------------------------------------------------------------------
module tb_intr_sequencer;

  localparam int DRAIN = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       intr_flag;
  logic       intr_clear;
  logic       halted;
  logic       hlt_clear;
  logic       instr_boundary;
  logic       rti;
  logic [7:0] ret_pc;
  logic [7:0] sp;
  logic       sp_dec;
  logic       stall;
  logic       flush;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       pc_load;
  logic [7:0] pc_next;
  logic       in_isr;
  logic       busy;

  logic [7:0] mem [256];
  logic [7:0] vec_val;

  int total  = 0;
  int passed = 0;

  intr_sequencer #(
    .DATA_W       (8),
    .VECTOR_ADDR  (8'h01),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .intr_flag      (intr_flag),
    .intr_clear     (intr_clear),
    .halted         (halted),
    .hlt_clear      (hlt_clear),
    .instr_boundary (instr_boundary),
    .rti            (rti),
    .ret_pc         (ret_pc),
    .sp             (sp),
    .sp_dec         (sp_dec),
    .stall          (stall),
    .flush          (flush),
    .mem_we         (mem_we),
    .mem_re         (mem_re),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .pc_load        (pc_load),
    .pc_next        (pc_next),
    .in_isr         (in_isr),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, one-cycle read latency; address 01 holds
  // the vector supplied by the bench.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= (mem_addr == 8'h01) ? vec_val : mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else passed++;
  endtask

  // Checks the DRAIN_CYCLES+3 cycles following an accept cycle plus the
  // first IDLE cycle afterwards.
  task automatic expect_entry(input logic [7:0] epc, input logic [7:0] esp,
                              input logic [7:0] evec, input logic ehlt);
    for (int i = 0; i < DRAIN; i++) begin
      @(negedge clk);
      intr_flag      = 1'b0;
      instr_boundary = 1'b0;
      #1;
      check("drain_stall", stall, 1);
      check("drain_flush", flush, 1);
      check("drain_busy",  busy,  1);
      check("drain_we",    mem_we, 0);
    end
    @(negedge clk); #1;
    check("push_we",     mem_we,     1);
    check("push_addr",   mem_addr,   esp);
    check("push_wdata",  mem_wdata,  epc);
    check("push_spdec",  sp_dec,     1);
    check("push_iclr",   intr_clear, 1);
    check("push_hclr",   hlt_clear,  ehlt);
    check("push_flush",  flush,      0);
    check("push_stall",  stall,      1);
    check("push_pcload", pc_load,    0);
    @(negedge clk); #1;
    check("vreq_re",    mem_re,     1);
    check("vreq_addr",  mem_addr,   8'h01);
    check("vreq_we",    mem_we,     0);
    check("vreq_iclr",  intr_clear, 0);
    @(negedge clk); #1;
    check("vload_pcload", pc_load, 1);
    check("vload_pcnext", pc_next, evec);
    check("vload_stall",  stall,   1);
    check("vload_inisr",  in_isr,  0);
    @(negedge clk); #1;
    check("post_inisr",  in_isr,  1);
    check("post_busy",   busy,    0);
    check("post_stall",  stall,   0);
    check("post_pcload", pc_load, 0);
    check("post_mem",    mem[esp], epc);
  endtask

  // One-cycle RTI pulse with nothing pending.
  task automatic do_rti();
    @(negedge clk);
    rti = 1'b1;
    #1;
    check("rti_inisr_hold", in_isr, 1);
    @(negedge clk);
    rti = 1'b0;
    #1;
    check("rti_inisr_clr", in_isr, 0);
    check("rti_busy",      busy,   0);
  endtask

  initial begin
    rst = 1'b0; intr_flag = 1'b0; halted = 1'b0; instr_boundary = 1'b0;
    rti = 1'b0; ret_pc = 8'h00; sp = 8'hFF; vec_val = 8'h80;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy",   busy,     0);
    check("rst_stall",  stall,    0);
    check("rst_inisr",  in_isr,   0);
    check("rst_addr",   mem_addr, 8'h00);
    check("rst_pcnext", pc_next,  8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Basic entry.
    @(negedge clk);
    intr_flag = 1'b1; instr_boundary = 1'b1; ret_pc = 8'h24; sp = 8'hFF;
    #1;
    check("basic_accept_busy", busy, 0);
    expect_entry(8'h24, 8'hFF, 8'h80, 1'b0);

    // Masking: pending interrupt ignored while in_isr.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      intr_flag = 1'b1; instr_boundary = 1'b1;
      #1;
      check("mask_busy", busy, 0);
    end
    @(negedge clk);
    rti = 1'b1; ret_pc = 8'h37; sp = 8'hFE;
    #1;
    check("mask_rti_inisr", in_isr, 1);
    check("mask_rti_busy",  busy,   0);
    @(negedge clk);
    rti = 1'b0;
    #1;
    check("mask_after_inisr", in_isr, 0);
    check("mask_after_busy",  busy,   0);
    expect_entry(8'h37, 8'hFE, 8'h80, 1'b0);
    do_rti();

    // Stray RTI.
    @(negedge clk);
    rti = 1'b1;
    #1;
    check("stray_inisr", in_isr, 0);
    check("stray_busy",  busy,   0);
    @(negedge clk);
    rti = 1'b0;
    #1;
    check("stray_inisr2", in_isr, 0);
    check("stray_stall",  stall,  0);

    // No boundary until the sixth cycle.
    vec_val = 8'h9A; ret_pc = 8'h50; sp = 8'hFD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      intr_flag = 1'b1; instr_boundary = 1'b0;
      #1;
      check("nobnd_busy",  busy,  0);
      check("nobnd_stall", stall, 0);
    end
    @(negedge clk);
    instr_boundary = 1'b1;
    #1;
    check("nobnd_accept_busy", busy, 0);
    expect_entry(8'h50, 8'hFD, 8'h9A, 1'b0);
    do_rti();

    // Halt wake.
    @(negedge clk);
    halted = 1'b1; instr_boundary = 1'b0; intr_flag = 1'b1;
    ret_pc = 8'h61; sp = 8'hFC; vec_val = 8'h40;
    #1;
    check("halt_accept_busy", busy, 0);
    expect_entry(8'h61, 8'hFC, 8'h40, 1'b1);
    halted = 1'b0;
    do_rti();

    // Reset during VREQ, then a fresh sequence.
    @(negedge clk);
    intr_flag = 1'b1; instr_boundary = 1'b1; ret_pc = 8'h72; sp = 8'hFB;
    repeat (DRAIN + 2) @(negedge clk);
    intr_flag = 1'b0; instr_boundary = 1'b0;
    #1;
    check("mid_vreq_re", mem_re, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy",  busy,     0);
    check("mid_rst_re",    mem_re,   0);
    check("mid_rst_stall", stall,    0);
    check("mid_rst_addr",  mem_addr, 8'h00);
    check("mid_rst_inisr", in_isr,   0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    intr_flag = 1'b1; instr_boundary = 1'b1; ret_pc = 8'h88; sp = 8'hFA; vec_val = 8'h11;
    #1;
    check("fresh_accept_busy", busy, 0);
    expect_entry(8'h88, 8'hFA, 8'h11, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
